hazard_tag_pipe: RTL and testbench
==================================

# hazard_tag_pipe

Producer side of the operand-forwarding path. This block carries register-destination tags through the ID/EX, EX/MEM and MEM/WB stages and drives the `EXMEM_RD`, `MEMWB_RD`, `EXMEM_RegWrite`, `MEMWB_RegWrite`, `IDEX_RS` and `IDEX_RT` signals that the forwarding comparator consumes. It also detects load-use hazards, applies branch flushes and memory stalls to the tag pipeline, and generates the PC/IF-ID hold and flush controls.

## Interface
Parameters:
- `MULDIV_LAT`, default 4: total EX-stage cycles for a mul/div instruction (≥1). Used only with `MULDIV_STALL_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ID_RS1`, `ID_RS2`, `ID_RD` in 5 each: register fields of the instruction in ID.
- `ID_RegWrite`, `ID_MemRead`, `ID_MulDiv` in 1 each: decoded controls of the ID instruction.
- `EX_BranchTaken` in 1: a branch or jump in EX redirects fetch.
- `MEM_Stall` in 1: the data memory is not ready; freeze the whole pipe.
- `IDEX_RS`, `IDEX_RT`, `IDEX_RD` out 5 each: ID/EX tags.
- `IDEX_RegWrite`, `IDEX_MemRead` out 1 each.
- `EXMEM_RD`, `MEMWB_RD` out 5 each; `EXMEM_RegWrite`, `MEMWB_RegWrite` out 1 each.
- `Stall` out 1: hold the PC and IF/ID (combinational).
- `IFID_Flush` out 1: squash IF/ID (combinational, equals `EX_BranchTaken` when `MEM_Stall` is 0).

## Operation
- Tag capture: `RegWrite` is stored as `ID_RegWrite && ID_RD!=0`. An x0 destination never produces an asserted RegWrite tag. Downstream comparators do not mask x0.
- Bubble: RS, RT and RD are 0, and RegWrite and MemRead are 0.
- Per-edge priority, highest first:
  1. `MEM_Stall`: all tag registers and the mul/div counter hold. `Stall`=1 and `IFID_Flush`=0.
  2. `EX_BranchTaken`: ID/EX loads a bubble. EX/MEM and MEM/WB advance. `IFID_Flush`=1 and `Stall`=0.
  3. Mul/div busy (macro only): ID/EX holds, EX/MEM loads a bubble, MEM/WB advances, `Stall`=1.
  4. Load-use: the condition is `IDEX_MemRead && IDEX_RegWrite && (IDEX_RD==ID_RS1 || IDEX_RD==ID_RS2)`. ID/EX loads a bubble, EX/MEM and MEM/WB advance, `Stall`=1.
  5. Otherwise: ID→ID/EX→EX/MEM→MEM/WB all advance and `Stall`=0.
- EX/MEM copies the RD and RegWrite of ID/EX. MEM/WB copies those of EX/MEM.
- When the load-use comparison matches on both RS1 and RS2, the result is a single stall cycle.

## Timing
- Reset: every tag output, RegWrite and MemRead output is 0, and the mul/div counter is 0. `Stall`=0 and `IFID_Flush`=0 while `rst` is high, regardless of inputs.
- Reset asserted mid-stall or mid-mul/div: state clears immediately. The first edge after release is a normal advance.
- Tag latency: ID→`IDEX_*` 1 cycle, →`EXMEM_*` 2 cycles, →`MEMWB_*` 3 cycles, when there are no stalls.
- `Stall` and `IFID_Flush` are combinational from the current state and inputs in the same cycle.
- A load-use stall lasts exactly 1 cycle. The following cycle the load is in EX/MEM and the dependent instruction proceeds using MEM/WB forwarding one cycle later.
- `MEM_Stall` held for N cycles extends every in-flight tag's lifetime by N cycles. `EX_BranchTaken` is sampled only once `MEM_Stall` drops.

## Configuration
- `MULDIV_STALL_EN` defined:
  - When a mul/div instruction is loaded into ID/EX, it loads counter = `MULDIV_LAT`-1.
  - While the counter is nonzero (and `MEM_Stall` is 0), priority 3 applies and the counter decrements by 1 per cycle.
  - When the counter reaches 0, the instruction advances normally.
  - `MULDIV_LAT`=1 gives no extra cycles.
  - Counter width is `$clog2(MULDIV_LAT)`, minimum 1 bit.
- `MULDIV_STALL_EN` undefined: `ID_MulDiv` is ignored, no counter exists, and priority 3 never occurs.

## Test plan
- Reset, then ADD x5 → next ADD: `IDEX_RD`=5 and `IDEX_RegWrite`=1 at cycle 1. `EXMEM_RD`=5 at cycle 2. `MEMWB_RD`=5 at cycle 3. `Stall` stays 0 throughout.
- LW x7 followed by ADD with rs2=7: `Stall`=1 for exactly one cycle. After the edge `IDEX_RD`=0 and `EXMEM_RD`=7. The ADD enters ID/EX on the next edge.
- ADDI x0 in ID: `IDEX_RegWrite`=0. A following LW x0 with a consumer rs1=0 raises no stall.
- `EX_BranchTaken`=1 while a load-use match is also present: `IFID_Flush`=1, `Stall`=0, and ID/EX becomes a bubble. The same case with `MEM_Stall`=1 gives `Stall`=1, `IFID_Flush`=0, and all tags unchanged.
- With `MULDIV_STALL_EN` and `MULDIV_LAT`=4, MUL x9: `Stall`=1 for 3 cycles with `IDEX_RD`=9 held and `EXMEM_RD`=0. `EXMEM_RD`=9 is seen on the 4th edge after entry.
- `rst` asserted during the second mul/div stall cycle: all outputs are 0 immediately, and the first edge after release advances normally.

Source files
------------

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe
//
// Producer side of the operand-forwarding path. Carries destination-register
// tags through the ID/EX, EX/MEM and MEM/WB stages for the forwarding
// comparator. Also detects load-use hazards, applies branch flushes and memory
// stalls to the tag pipeline, and drives the PC/IF-ID hold and flush controls.
//
// Optional feature: define MULDIV_STALL_EN to hold a mul/div instruction in EX
// for MULDIV_LAT cycles in total. Without the macro, ID_MulDiv is ignored.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   ID_RS1, ID_RS2, ID_RD         register fields of the instruction in ID
//   ID_RegWrite, ID_MemRead,
//   ID_MulDiv                     decoded controls of the ID instruction
//   EX_BranchTaken                branch/jump in EX redirects fetch
//   MEM_Stall                     data memory not ready, freeze the whole pipe
//   IDEX_RS/RT/RD, IDEX_RegWrite,
//   IDEX_MemRead                  ID/EX tags
//   EXMEM_RD, EXMEM_RegWrite      EX/MEM tags
//   MEMWB_RD, MEMWB_RegWrite      MEM/WB tags
//   Stall                         hold PC and IF/ID (combinational)
//   IFID_Flush                    squash IF/ID (combinational)

module hazard_tag_pipe #(
    parameter int MULDIV_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic [4:0] ID_RD,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       ID_MulDiv,
    input  logic       EX_BranchTaken,
    input  logic       MEM_Stall,
    output logic [4:0] IDEX_RS,
    output logic [4:0] IDEX_RT,
    output logic [4:0] IDEX_RD,
    output logic       IDEX_RegWrite,
    output logic       IDEX_MemRead,
    output logic [4:0] EXMEM_RD,
    output logic [4:0] MEMWB_RD,
    output logic       EXMEM_RegWrite,
    output logic       MEMWB_RegWrite,
    output logic       Stall,
    output logic       IFID_Flush
);

    // An x0 destination never produces an asserted RegWrite tag, so the
    // downstream comparators need not mask x0.
    logic id_regwrite;
    assign id_regwrite = ID_RegWrite && (ID_RD != 5'd0);

    // IDEX_RegWrite already excludes x0, so a load to x0 never stalls.
    logic load_use;
    assign load_use = IDEX_MemRead && IDEX_RegWrite &&
                      ((IDEX_RD == ID_RS1) || (IDEX_RD == ID_RS2));

    logic busy;

`ifdef MULDIV_STALL_EN
    localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 1);

    logic [CW-1:0] count;
    assign busy = (count != '0);
`else
    assign busy = 1'b0;

    // Inputs unused in this build are folded into one sink.
    logic unused_muldiv;
    assign unused_muldiv = ID_MulDiv ^ (MULDIV_LAT == 0);
`endif

    // Priority: memory stall, branch flush, mul/div busy, load-use, advance.
    assign Stall      = !rst && (MEM_Stall || (!EX_BranchTaken && (busy || load_use)));
    assign IFID_Flush = !rst && !MEM_Stall && EX_BranchTaken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IDEX_RS        <= 5'd0;
            IDEX_RT        <= 5'd0;
            IDEX_RD        <= 5'd0;
            IDEX_RegWrite  <= 1'b0;
            IDEX_MemRead   <= 1'b0;
            EXMEM_RD       <= 5'd0;
            EXMEM_RegWrite <= 1'b0;
            MEMWB_RD       <= 5'd0;
            MEMWB_RegWrite <= 1'b0;
`ifdef MULDIV_STALL_EN
            count          <= '0;
`endif
        end else if (MEM_Stall) begin
            // Whole pipe frozen, including the mul/div counter.
        end else begin
            MEMWB_RD       <= EXMEM_RD;
            MEMWB_RegWrite <= EXMEM_RegWrite;
            if (!EX_BranchTaken && busy) begin
                // Mul/div still executing: ID/EX holds, EX/MEM takes a bubble.
                EXMEM_RD       <= 5'd0;
                EXMEM_RegWrite <= 1'b0;
`ifdef MULDIV_STALL_EN
                count          <= count - 1'b1;
`endif
            end else begin
                EXMEM_RD       <= IDEX_RD;
                EXMEM_RegWrite <= IDEX_RegWrite;
                if (EX_BranchTaken || load_use) begin
                    IDEX_RS       <= 5'd0;
                    IDEX_RT       <= 5'd0;
                    IDEX_RD       <= 5'd0;
                    IDEX_RegWrite <= 1'b0;
                    IDEX_MemRead  <= 1'b0;
`ifdef MULDIV_STALL_EN
                    count         <= '0;
`endif
                end else begin
                    IDEX_RS       <= ID_RS1;
                    IDEX_RT       <= ID_RS2;
                    IDEX_RD       <= ID_RD;
                    IDEX_RegWrite <= id_regwrite;
                    IDEX_MemRead  <= ID_MemRead;
`ifdef MULDIV_STALL_EN
                    count         <= ID_MulDiv ? CNT_LOAD : '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed testbench for hazard_tag_pipe: a table of single-cycle vectors
// plus hand-written sequences for reset and the optional mul/div stall.

module tb_hazard_tag_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_RS1, ID_RS2, ID_RD;
    logic       ID_RegWrite, ID_MemRead, ID_MulDiv;
    logic       EX_BranchTaken, MEM_Stall;
    logic [4:0] IDEX_RS, IDEX_RT, IDEX_RD, EXMEM_RD, MEMWB_RD;
    logic       IDEX_RegWrite, IDEX_MemRead, EXMEM_RegWrite, MEMWB_RegWrite;
    logic       Stall, IFID_Flush;

    int errors = 0;
    int checks = 0;

    hazard_tag_pipe #(.MULDIV_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MulDiv(ID_MulDiv),
        .EX_BranchTaken(EX_BranchTaken), .MEM_Stall(MEM_Stall),
        .IDEX_RS(IDEX_RS), .IDEX_RT(IDEX_RT), .IDEX_RD(IDEX_RD),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
        .EXMEM_RD(EXMEM_RD), .MEMWB_RD(MEMWB_RD),
        .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
        .Stall(Stall), .IFID_Flush(IFID_Flush)
    );

    always #5 clk = ~clk;

    // Registered outputs packed as
    // {IDEX_RS, IDEX_RT, IDEX_RD, IDEX_RegWrite, IDEX_MemRead,
    //  EXMEM_RD, EXMEM_RegWrite, MEMWB_RD, MEMWB_RegWrite}
    function automatic logic [28:0] regs(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic rw,
                                         input logic mr, input logic [4:0] exrd,
                                         input logic exrw, input logic [4:0] wbrd,
                                         input logic wbrw);
        return {rs, rt, rd, rw, mr, exrd, exrw, wbrd, wbrw};
    endfunction

    function automatic logic [28:0] actual_regs();
        return {IDEX_RS, IDEX_RT, IDEX_RD, IDEX_RegWrite, IDEX_MemRead,
                EXMEM_RD, EXMEM_RegWrite, MEMWB_RD, MEMWB_RegWrite};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic md,
                         input logic br, input logic ms);
        ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd;
        ID_RegWrite = rw; ID_MemRead = mr; ID_MulDiv = md;
        EX_BranchTaken = br; MEM_Stall = ms;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, md, br, ms;
        logic        stall, flush;   // combinational, before the edge
        logic [28:0] after;          // registered outputs after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic md,
                       input logic br, input logic ms,
                       input logic stall, input logic flush, input logic [28:0] after);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.rw = rw; v.mr = mr; v.md = md; v.br = br; v.ms = ms;
        v.stall = stall; v.flush = flush; v.after = after;
        vecs.push_back(v);
    endtask

    initial begin
        // ---------------- Reset: outputs forced low regardless of inputs
        rst = 1'b1;
        drive(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        check("reset_stall", 32'(Stall), 32'd0);
        check("reset_flush", 32'(IFID_Flush), 32'd0);
        @(posedge clk); #1;
        check("reset_regs", 32'(actual_regs()), 32'd0);
        rst = 1'b0;

        // ---------------- Vector table
        //  rs1 rs2 rd rw mr md br ms | stall flush | after-edge registers
        add(1, 2, 5,  1, 0, 0, 0, 0,  0, 0, regs(1, 2, 5, 1, 0,   0, 0,   0, 0));  // ADD x5
        add(5, 3, 6,  1, 0, 0, 0, 0,  0, 0, regs(5, 3, 6, 1, 0,   5, 1,   0, 0));  // ADD x6
        add(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, regs(0, 0, 0, 0, 0,   6, 1,   5, 1));  // NOP
        add(2, 0, 7,  1, 1, 0, 0, 0,  0, 0, regs(2, 0, 7, 1, 1,   0, 0,   6, 1));  // LW x7
        add(4, 7, 8,  1, 0, 0, 0, 0,  1, 0, regs(0, 0, 0, 0, 0,   7, 1,   0, 0));  // load-use rs2
        add(4, 7, 8,  1, 0, 0, 0, 0,  0, 0, regs(4, 7, 8, 1, 0,   0, 0,   7, 1));  // ADD proceeds
        add(1, 0, 0,  1, 0, 0, 0, 0,  0, 0, regs(1, 0, 0, 0, 0,   8, 1,   0, 0));  // ADDI x0
        add(3, 0, 0,  1, 1, 0, 0, 0,  0, 0, regs(3, 0, 0, 0, 1,   0, 0,   8, 1));  // LW x0
        add(0, 0, 9,  1, 0, 0, 0, 0,  0, 0, regs(0, 0, 9, 1, 0,   0, 0,   0, 0));  // rs1=0, no stall
        add(1, 0, 10, 1, 1, 0, 0, 0,  0, 0, regs(1, 0, 10, 1, 1,  9, 1,   0, 0));  // LW x10
        add(10, 10, 11, 1, 0, 0, 1, 0, 0, 1, regs(0, 0, 0, 0, 0,  10, 1,  9, 1));  // branch beats load-use
        add(0, 0, 12, 1, 1, 0, 0, 0,  0, 0, regs(0, 0, 12, 1, 1,  0, 0,   10, 1)); // LW x12
        add(12, 12, 13, 1, 0, 0, 1, 1, 1, 0, regs(0, 0, 12, 1, 1, 0, 0,   10, 1)); // mem stall beats branch
        add(12, 12, 13, 1, 0, 0, 0, 1, 1, 0, regs(0, 0, 12, 1, 1, 0, 0,   10, 1)); // mem stall holds
        add(12, 12, 13, 1, 0, 0, 0, 0, 1, 0, regs(0, 0, 0, 0, 0,  12, 1,  0, 0));  // double match, one stall
        add(12, 12, 13, 1, 0, 0, 0, 0, 0, 0, regs(12, 12, 13, 1, 0, 0, 0, 12, 1)); // consumer proceeds
`ifndef MULDIV_STALL_EN
        add(1, 2, 9,  1, 0, 1, 0, 0,  0, 0, regs(1, 2, 9, 1, 0,   13, 1,  0, 0));  // MulDiv ignored
        add(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, regs(0, 0, 0, 0, 0,   9, 1,   13, 1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw,
                  vecs[i].mr, vecs[i].md, vecs[i].br, vecs[i].ms);
            #1;
            check($sformatf("vec%0d_stall", i), 32'(Stall), 32'(vecs[i].stall));
            check($sformatf("vec%0d_flush", i), 32'(IFID_Flush), 32'(vecs[i].flush));
            @(posedge clk); #1;
            check($sformatf("vec%0d_regs", i), 32'(actual_regs()), 32'(vecs[i].after));
        end

        // ---------------- Reset asserted while a load-use stall is pending
        drive(2, 0, 7, 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        drive(4, 7, 8, 1, 0, 0, 0, 0);
        #1;
        check("pre_rst_stall", 32'(Stall), 32'd1);
        rst = 1'b1;
        #1;
        check("midstall_rst_regs", 32'(actual_regs()), 32'd0);
        check("midstall_rst_stall", 32'(Stall), 32'd0);
        #2;
        rst = 1'b0;
        drive(1, 2, 5, 1, 0, 0, 0, 0);
        #1;
        check("post_rst_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        check("post_rst_advance", 32'(actual_regs()), 32'(regs(1, 2, 5, 1, 0, 0, 0, 0, 0)));

`ifdef MULDIV_STALL_EN
        // ---------------- MUL x9 with MULDIV_LAT=4: three stall cycles
        drive(1, 2, 9, 1, 0, 1, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("mul_stall%0d", c), 32'(Stall), 32'd1);
            @(posedge clk); #1;
            check($sformatf("mul_hold_rd%0d", c), 32'(IDEX_RD), 32'd9);
            check($sformatf("mul_exmem_rd%0d", c), 32'(EXMEM_RD), 32'd0);
        end
        #1;
        check("mul_done_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        check("mul_exmem_9", 32'(EXMEM_RD), 32'd9);

        // ---------------- Reset during the second mul/div stall cycle
        drive(1, 2, 9, 1, 0, 1, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("mul2_stall", 32'(Stall), 32'd1);
        rst = 1'b1;
        #1;
        check("mul_rst_regs", 32'(actual_regs()), 32'd0);
        check("mul_rst_stall", 32'(Stall), 32'd0);
        #2;
        rst = 1'b0;
        drive(3, 4, 6, 1, 0, 0, 0, 0);
        #1;
        check("mul_post_rst_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        check("mul_post_rst_adv", 32'(actual_regs()), 32'(regs(3, 4, 6, 1, 0, 0, 0, 0, 0)));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
